// File: rtl/exu_stage_ctrl.sv
// EX-stage sequencer: ID/WB handshakes, ID_EX load enable, MDU start/done/timeout, ebreak halt.
// Optional performance counters are compiled in when EXU_PERF_CNT_EN is defined.
module exu_stage_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        id_valid,
    input  logic        id_multi,
    input  logic        id_ebreak,
    output logic        id_ready,
    output logic        ex_ld_en,
    input  logic        flush,
    output logic        mdu_start,
    output logic        mdu_abort,
    input  logic        mdu_done,
    output logic        ex_valid,
    input  logic        ex_ready,
    output logic        ex_err,
    output logic        retire,
    output logic        halted
`ifdef EXU_PERF_CNT_EN
    ,
    output logic [31:0] perf_retired,
    output logic [31:0] perf_stall
`endif
);

    typedef enum logic [1:0] {IDLE, EXEC, MDU_WAIT, HALT} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MDU_TIMEOUT - 1);

    state_t           state, state_nx;
    logic             ebreak_q, ebreak_nx;
    logic             start_q, start_nx;
    logic             err_q, err_nx;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic             timeout;

    assign timeout = (cnt == CNT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ebreak_q <= 1'b0;
            start_q  <= 1'b0;
            err_q    <= 1'b0;
            cnt      <= '0;
        end else begin
            state    <= state_nx;
            ebreak_q <= ebreak_nx;
            start_q  <= start_nx;
            err_q    <= err_nx;
            cnt      <= cnt_nx;
        end
    end

    always_comb begin
        state_nx  = state;
        ebreak_nx = ebreak_q;
        start_nx  = 1'b0;
        err_nx    = err_q;
        cnt_nx    = cnt;
        id_ready  = 1'b0;
        mdu_abort = 1'b0;
        retire    = 1'b0;

        case (state)
            IDLE: id_ready = ~flush;
            EXEC: begin
                if (flush) begin
                    state_nx = IDLE;
                    err_nx   = 1'b0;
                end else if (ex_ready) begin
                    retire = 1'b1;
                    err_nx = 1'b0;
                    // A retiring ebreak must not pull in a successor it would then drop.
                    if (ebreak_q) begin
                        state_nx = HALT;
                    end else begin
                        id_ready = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            MDU_WAIT: begin
                if (flush) begin
                    state_nx  = IDLE;
                    mdu_abort = 1'b1;
                end else if (mdu_done) begin
                    state_nx = EXEC;
                    err_nx   = 1'b0;
                end else if (timeout) begin
                    state_nx  = EXEC;
                    err_nx    = 1'b1;
                    mdu_abort = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_W'(1);
                end
            end
            default: ;
        endcase

        if (id_valid && id_ready) begin
            state_nx  = id_multi ? MDU_WAIT : EXEC;
            ebreak_nx = id_ebreak;
            start_nx  = id_multi;
            cnt_nx    = '0;
            err_nx    = 1'b0;
        end

        // The MDU is reset by the same rst, so no abort is issued during reset.
        if (rst) begin
            id_ready  = 1'b0;
            mdu_abort = 1'b0;
            retire    = 1'b0;
        end
    end

    assign ex_ld_en  = id_valid & id_ready;
    assign mdu_start = start_q;
    assign ex_valid  = (state == EXEC);
    assign ex_err    = err_q;
    assign halted    = (state == HALT);

`ifdef EXU_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_retired <= '0;
            perf_stall   <= '0;
        end else if (state != HALT) begin
            perf_retired <= perf_retired + {31'd0, retire};
            perf_stall   <= perf_stall + {31'd0, (state == MDU_WAIT) || ((state == EXEC) && !ex_ready)};
        end
    end
`endif

endmodule
